// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM state encoding
// and register-field constants.
package pipe_hazard_ctrl_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        ERROR    = 2'd3
    } hz_state_e;

endpackage : pipe_hazard_ctrl_pkg

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use compare between the load in EX and the source
// fields of the instruction in ID.
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic             idex_memread_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    output logic             hz_o
);

    // r0 is hardwired to zero, so a load targeting it never creates a dependency
    assign hz_o = idex_memread_i && (idex_rt_i != REG_ZERO) &&
                  ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

endmodule : hazard_detect

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use stalls,
// branch flushes, data-memory waits with timeout, and a stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             start_i,
    input  logic             idex_memread_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    input  logic             branch_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    output logic             pc_write_o,
    output logic             ifid_stall_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_freeze_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    hz_state_e        state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             hz;

    logic run_pc_write, run_stall, run_flush, run_bubble;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    hazard_detect u_hazard_detect (
        .idex_memread_i (idex_memread_i),
        .idex_rt_i      (idex_rt_i),
        .ifid_rs_i      (ifid_rs_i),
        .ifid_rt_i      (ifid_rt_i),
        .hz_o           (hz)
    );

    // RUN-state rules 2-4, shared by RUN and the MEM_WAIT ack cycle;
    // a hazard masks the branch because the ID operands are stale
    always_comb begin
        run_pc_write = 1'b1;
        run_stall    = 1'b0;
        run_flush    = 1'b0;
        run_bubble   = 1'b0;
        if (hz) begin
            run_pc_write = 1'b0;
            run_stall    = 1'b1;
            run_bubble   = 1'b1;
        end else if (branch_taken_i) begin
            run_flush    = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_err_d     = mem_err_q;
        pc_write_o    = 1'b0;
        ifid_stall_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_freeze_o = 1'b0;
        unique case (state_q)
            BOOT: begin
                ifid_flush_o  = 1'b1;
                idex_bubble_o = 1'b1;
                state_d       = RUN;
            end
            RUN: begin
                if (dmem_req_i && !dmem_ack_i) begin
                    ifid_stall_o  = 1'b1;
                    pipe_freeze_o = 1'b1;
                    state_d       = MEM_WAIT;
                    wait_cnt_d    = WC_W'(1);
                end else begin
                    pc_write_o    = run_pc_write;
                    ifid_stall_o  = run_stall;
                    ifid_flush_o  = run_flush;
                    idex_bubble_o = run_bubble;
                end
            end
            MEM_WAIT: begin
                if (!dmem_ack_i) begin
                    ifid_stall_o  = 1'b1;
                    pipe_freeze_o = 1'b1;
                    wait_cnt_d    = wait_cnt_q + 1'b1;
                    if (wait_cnt_q == WC_LAST) begin
                        state_d   = ERROR;
                        mem_err_d = 1'b1;
                    end
                end else begin
                    pc_write_o    = run_pc_write;
                    ifid_stall_o  = run_stall;
                    ifid_flush_o  = run_flush;
                    idex_bubble_o = run_bubble;
                    state_d       = RUN;
                    wait_cnt_d    = '0;
                end
            end
            ERROR: begin
                ifid_flush_o  = 1'b1;
                idex_bubble_o = 1'b1;
                pipe_freeze_o = 1'b1;
            end
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == RUN || state_q == MEM_WAIT) && !pc_write_o)
            stall_cnt_d = sat_inc(stall_cnt_q);
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q     <= BOOT;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_err_o   = mem_err_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule : pipe_hazard_ctrl

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the PC write enable, the IF/ID hold and flush controls, the ID/EX bubble insert, and a freeze of the downstream stage registers.
- Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits, with a timeout error.
- Provides a saturating stall-cycle performance counter.

Parameters:
- MEM_TIMEOUT, 16: max cycles spent in MEM_WAIT before declaring a memory error (>=2).
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk_i  input  1  clock, rising edge.
- start_i  input  1  asynchronous active-low reset.
- idex_memread_i  input  1  instruction in EX is a load.
- idex_rt_i  input  5  destination register of the load in EX.
- ifid_rs_i  input  5  rs field of the instruction in ID.
- ifid_rt_i  input  5  rt field of the instruction in ID.
- branch_taken_i  input  1  branch resolved taken in ID this cycle.
- dmem_req_i  input  1  MEM stage issuing a data-memory access.
- dmem_ack_i  input  1  data memory completes the access this cycle.
- pc_write_o  output  1  1 = PC loads next address.
- ifid_stall_o  output  1  1 = IF/ID holds contents (IF/ID stall input).
- ifid_flush_o  output  1  1 = IF/ID clears to zero (IF/ID flush input).
- idex_bubble_o  output  1  1 = ID/EX loads a NOP (all controls 0).
- pipe_freeze_o  output  1  1 = ID/EX, EX/MEM and MEM/WB hold.
- mem_err_o  output  1  sticky memory-timeout flag.
- stall_cnt_o  output  CNT_W  stall cycles since reset, saturating.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-low on start_i. While start_i=0: state=BOOT, wait_cnt=0, mem_err_o=0, stall_cnt_o=0.
- Outputs: combinational from state and inputs. Unlisted outputs are 0.
- Load-use hazard: hz = idex_memread_i & (idex_rt_i!=0) & (idex_rt_i==ifid_rs_i | idex_rt_i==ifid_rt_i).
- BOOT (first cycle after reset release):
  - pc_write_o=0, ifid_flush_o=1, idex_bubble_o=1.
  - Next state: RUN unconditionally.
- RUN, evaluated in priority order:
  1. dmem_req_i & !dmem_ack_i:
     - pc_write_o=0, ifid_stall_o=1, pipe_freeze_o=1.
     - Next state MEM_WAIT, wait_cnt<=1.
  2. hz:
     - pc_write_o=0, ifid_stall_o=1, idex_bubble_o=1.
     - branch_taken_i is ignored because ID operands are stale; the branch re-resolves next cycle.
  3. branch_taken_i: pc_write_o=1, ifid_flush_o=1.
  4. Otherwise: pc_write_o=1, all other controls 0.
  - A dmem_req_i with dmem_ack_i in the same cycle completes with zero wait; rules 2-4 apply.
- MEM_WAIT:
  - If !dmem_ack_i: outputs as RUN rule 1; wait_cnt<=wait_cnt+1.
  - If !dmem_ack_i and wait_cnt==MEM_TIMEOUT-1: next state ERROR, mem_err_o<=1.
  - If dmem_ack_i: freeze released in this same cycle; RUN rules 2-4 apply combinationally; next state RUN; wait_cnt<=0.
  - Total freeze length is cycles-to-ack, at most MEM_TIMEOUT.
- ERROR:
  - pc_write_o=0, ifid_flush_o=1, idex_bubble_o=1, pipe_freeze_o=1, mem_err_o=1.
  - Exit only by reset.
- stall_cnt_o:
  - +1 on each clock edge where state is RUN or MEM_WAIT and pc_write_o=0.
  - Holds at 2^CNT_W-1 (saturates).
  - Never counts in BOOT or ERROR.
- Reset mid-wait: aborts immediately to BOOT and clears all registers.
- ifid_stall_o and ifid_flush_o are never both 1.

Decomposition:
- Shared pipeline package holds:
  - the state encoding (BOOT=0, RUN=1, MEM_WAIT=2, ERROR=3, 2 bits);
  - the REG_ZERO=5'd0 constant;
  - the register-field width (5).
- One natural sub-module, hazard_detect: purely combinational load-use compare producing hz. FSM and counters stay in the top module.

Test Plan:
- Reset release: start_i 0->1 -> one BOOT cycle (flush=1, pc_write=0), then RUN with pc_write=1, stall_cnt=0.
- Load-use: idex_memread=1, idex_rt=5, ifid_rs=5 -> pc_write=0, ifid_stall=1, idex_bubble=1, stall_cnt +1. Same with idex_rt=0 -> no stall.
- Branch vs hazard: branch_taken=1 with no hazard -> ifid_flush=1, pc_write=1. branch_taken=1 together with a hazard -> stall only, flush=0.
- Memory wait: dmem_req=1, ack delayed 3 cycles -> pipe_freeze=1 for exactly 3 cycles, released on the ack cycle, stall_cnt +3.
- Timeout: MEM_TIMEOUT=4, dmem_req=1, ack never arrives -> ERROR after 4 frozen cycles, mem_err=1 sticky; start_i pulse low clears it.
- Saturation: CNT_W=3, 9 consecutive hazard cycles -> stall_cnt_o stops at 7.
